// File: rtl/result_bcd_converter_pkg.sv
// result_bcd_converter_pkg: shared FSM encoding and seven-segment constants
// Segment patterns are active-low in g..a order (bit 6 = g, bit 0 = a).
package result_bcd_converter_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   // Index 9 first so that SEG_TABLE[d] yields the pattern for digit d.
   localparam logic [9:0][6:0] SEG_TABLE = {
      7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
      7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
   };
endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: one BCD nibble to active-low seven-segment pattern
// Ports: d = BCD digit in, seg = active-low segments g..a out.
// Values above 9 never occur from the converter and decode as blank.
module bcd_to_7seg
   import result_bcd_converter_pkg::*;
(
   input  logic [3:0] d,
   output logic [6:0] seg
);
   assign seg = (d <= 4'd9) ? SEG_TABLE[d] : SEG_BLANK;
endmodule

// File: rtl/result_bcd_converter.sv
// result_bcd_converter: sequential double-dabble conversion of an adder result to BCD and seven-segment
// Ports: Clock/Reset (async, active-high); Z, Overflow, Signed, Start in;
//        Busy, Done, Digits (packed BCD, digit 0 in [3:0]), Negative, OvfOut, HEX (active-low, sign on top) out.
module result_bcd_converter
   import result_bcd_converter_pkg::*;
#(
   parameter int n  = 8,
   parameter int ND = 3
)(
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic [n-1:0]          Z,
   input  logic                  Overflow,
   input  logic                  Signed,
   input  logic                  Start,
   output logic                  Busy,
   output logic                  Done,
   output logic [4*ND-1:0]       Digits,
   output logic                  Negative,
   output logic                  OvfOut,
   output logic [7*(ND+1)-1:0]   HEX
);
   localparam int CW = $clog2(n + 1);
   state_t state, state_next;
   logic [CW-1:0] cnt;
   logic [4*ND-1:0] bcd, bcd_adj;
   logic [n-1:0] mag, mag_load;
   logic [4*ND+n-1:0] sh;
   logic neg_c, ovf_c, is_neg, last;
   assign is_neg   = Signed && Z[n-1];
   // Two's-complement negate in n bits; -2^(n-1) maps onto itself, read as unsigned 2^(n-1).
   assign mag_load = is_neg ? (~Z) + n'(1) : Z;
   assign last     = (cnt == CW'(n - 1));
   assign sh       = {bcd_adj, mag} << 1;
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < ND; i++)
         bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
   end
   always_comb begin
      state_next = state;
      Busy       = 1'b0;
      Done       = 1'b0;
      unique case (state)
         IDLE:    state_next = Start ? SHIFT : IDLE;
         SHIFT: begin
            Busy       = 1'b1;
            state_next = last ? DONE : SHIFT;
         end
         DONE: begin
            Done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state    <= IDLE;
         cnt      <= '0;
         bcd      <= '0;
         mag      <= '0;
         neg_c    <= 1'b0;
         ovf_c    <= 1'b0;
         Digits   <= '0;
         Negative <= 1'b0;
         OvfOut   <= 1'b0;
      end else begin
         state <= state_next;
         if (state == IDLE && Start) begin
            cnt   <= '0;
            bcd   <= '0;
            mag   <= mag_load;
            neg_c <= is_neg;
            ovf_c <= Overflow;
         end else if (state == SHIFT) begin
            {bcd, mag} <= sh;
            cnt        <= cnt + CW'(1);
            // Final iteration: publish the shifted result directly so all three outputs change together.
            if (last) begin
               Digits   <= sh[n +: 4*ND];
               Negative <= neg_c;
               OvfOut   <= ovf_c;
            end
         end
      end
   end
   genvar g;
   generate
      for (g = 0; g < ND; g++) begin : g_seg
         bcd_to_7seg u_seg (.d(Digits[4*g +: 4]), .seg(HEX[7*g +: 7]));
      end
   endgenerate
   assign HEX[7*ND +: 7] = Negative ? SEG_MINUS : SEG_BLANK;
endmodule

// File: doc/result_bcd_converter.md
RESULT_BCD_CONVERTER -- requirements
Module: result_bcd_converter

Interface
REQ-001 SHALL have parameter n, default 8: result width in bits.
REQ-002 SHALL have parameter ND, default 3: number of BCD digits; 10^ND > 2^n required.
REQ-003 SHALL have port Clock  input  1  single system clock, rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Z  input  n  result word from the adder/subtractor stage.
REQ-006 SHALL have port Overflow  input  1  overflow flag paired with Z.
REQ-007 SHALL have port Signed  input  1  1 = treat Z as two's complement; 0 = unsigned.
REQ-008 SHALL have port Start  input  1  conversion request, level-sampled.
REQ-009 SHALL have port Busy  output  1  conversion in progress.
REQ-010 SHALL have port Done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port Digits  output  4*ND  packed BCD magnitude, digit 0 in [3:0].
REQ-012 SHALL have port Negative  output  1  captured value was negative (Signed only).
REQ-013 SHALL have port OvfOut  output  1  Overflow captured with the displayed result.
REQ-014 SHALL have port HEX  output  7*(ND+1)  active-low segments: HEX digit i = Digits digit i; top field = sign.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-016 In IDLE with Start=1 at an edge, SHALL capture Z, Overflow and Signed, and enter SHIFT.
REQ-017 On capture, SHALL load magnitude = -Z (mod 2^n, n-bit unsigned) when Signed=1 and Z[n-1]=1; otherwise magnitude = Z.
REQ-018 The magnitude of -2^(n-1) SHALL be 2^(n-1) (8'h80 -> 128).
REQ-019 In SHIFT, SHALL perform one double-dabble iteration per cycle: add 3 to each BCD nibble >= 5, then shift {bcd, mag} left by 1.
REQ-020 SHALL perform exactly n iterations, counted by an iteration counter, then enter DONE.
REQ-021 On the edge entering DONE, SHALL update Digits, Negative and OvfOut together.
REQ-022 Digits, Negative and OvfOut SHALL hold their previous values at all other times.
REQ-023 Busy SHALL be 1 exactly while in SHIFT: n cycles, starting the cycle after the Start edge.
REQ-024 Done SHALL be 1 only while in DONE, for exactly one cycle.
REQ-025 DONE SHALL return to IDLE unconditionally on the next edge.
REQ-026 Start SHALL be ignored in SHIFT and DONE; the Z and Overflow inputs SHALL be ignored outside the capture edge.
REQ-027 Start held high SHALL produce back-to-back conversions: one accepted per IDLE visit, n+2 cycles apart.
REQ-028 HEX SHALL decode combinationally from the registered Digits and Negative.
REQ-029 Sign field SHALL be 7'b0111111 (minus) when Negative=1, else 7'b1111111 (blank).
REQ-030 Digit patterns SHALL use the active-low g..a order: 0 = 7'b1000000.
REQ-031 Nibble values above 9, which are unreachable, SHALL decode as blank.

Reset
REQ-032 Reset=1 SHALL asynchronously force state IDLE, counter 0, Busy=0, Done=0, Digits=0, Negative=0 and OvfOut=0.
REQ-033 During reset, HEX digits SHALL show "0" and the sign field SHALL be blank.
REQ-034 Reset asserted mid-conversion SHALL abort the conversion; Done SHALL not pulse for the aborted request.

Structure
REQ-035 Shared package SHALL hold the FSM state encoding, the segment constants SEG_BLANK and SEG_MINUS, and the 0-9 segment table.
REQ-036 SHALL contain one sub-module, bcd_to_7seg (4-bit in, 7-bit active-low out), instantiated ND times.
REQ-037 The sign field SHALL be driven by direct constant selection, not by a bcd_to_7seg instance.
REQ-038 All sequential logic SHALL reside in one clocked process on Clock with asynchronous Reset.

Verification
REQ-039 Signed=0, Z=8'hFF, Start pulse -> Busy high 8 cycles, Done pulse, Digits=12'h255, Negative=0, HEX shows 2,5,5.
REQ-040 Signed=1, Z=8'h80 -> Digits=12'h128, Negative=1, sign field 7'b0111111; Signed=1, Z=8'hFB -> 12'h005, Negative=1.
REQ-041 Signed=0, Z=8'h00 and Signed=1, Z=8'h7F -> Digits 12'h000 then 12'h127, Negative=0 both.
REQ-042 Start accepted with Z=8'h0A, then Start=1 with Z=8'h63 during Busy -> single Done, Digits=12'h010.
REQ-043 Reset asserted during the 4th SHIFT cycle -> all outputs at reset values at once, no Done; next Start with Z=8'h2A -> 12'h042.
REQ-044 Overflow=1 with Z=8'h81, Signed=1 -> OvfOut=1, Digits=12'h127, Negative=1; OvfOut holds until the next completion.
